// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM states, width codes and byte-enable patterns shared by
// lsu_seq and lsu_align. LSU_MISALIGN_SPLIT_EN adds the REQ2/WAIT2 states.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
`ifdef LSU_MISALIGN_SPLIT_EN
        REQ2  = 3'd4,
        WAIT2 = 3'd5,
`endif
        DONE  = 3'd3
    } state_t;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    function automatic logic funct_illegal(
        input logic       is_ld,
        input logic [2:0] f
    );
        logic bad;
        if (is_ld)
            bad = !(f inside {F_B, F_H, F_W, F_BU, F_HU});
        else
            bad = !(f inside {F_B, F_H, F_W});
        return bad;
    endfunction

    // True when the access would cross a word boundary.
    function automatic logic misaligned(
        input logic [2:0] f,
        input logic [1:0] off
    );
        logic m;
        case (f)
            F_H, F_HU: m = (off == 2'b11);
            F_W:       m = (off != 2'b00);
            default:   m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane shift, load extension and byte-enable generation.
// Ports: funct/off/wdata/rdata in; hi selects beat; be, wdata_sh, ld_data out.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct,
    input  logic [1:0]  off,
    input  logic        hi,
    input  logic [31:0] wdata,
    input  logic [63:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] ld_data
);

    logic [4:0]  sh;
    logic [3:0]  be_base;
    logic [7:0]  be8;
    logic [63:0] w64;
    logic [31:0] lo;

    assign sh = {off, 3'b000};

    always_comb begin
        case (funct[1:0])
            2'b00:   be_base = BE_B;
            2'b01:   be_base = BE_H;
            default: be_base = BE_W;
        endcase
    end

    // Lanes are laid out over two words so that a split access
    // simply takes the upper half on its second beat.
    assign be8      = 8'({4'b0000, be_base} << off);
    assign w64      = {32'b0, wdata} << sh;
    assign be       = hi ? be8[7:4] : be8[3:0];
    assign wdata_sh = hi ? w64[63:32] : w64[31:0];

    assign lo = 32'(rdata >> sh);

    always_comb begin
        case (funct)
            F_B:     ld_data = {{24{lo[7]}}, lo[7:0]};
            F_H:     ld_data = {{16{lo[15]}}, lo[15:0]};
            F_BU:    ld_data = {24'b0, lo[7:0]};
            F_HU:    ld_data = {16'b0, lo[15:0]};
            default: ld_data = lo;
        endcase
    end

endmodule

// File: rtl/lsu_seq.sv
// lsu_seq: load/store sequencer between execute stage and a gnt/rvalid bus.
// Ports: memRd/memWr/funct/addr/wdata in; stall/done/err/ld_data out;
// mem_req/we/addr/be/wdata out, mem_gnt/rvalid/rdata in.
// LSU_MISALIGN_SPLIT_EN: split word-crossing accesses into two beats.
module lsu_seq
    import lsu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         memRd,
    input  logic         memWr,
    input  logic [2:0]   funct,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] wdata,
    output logic         stall,
    output logic         done,
    output logic         err,
    output logic [N-1:0] ld_data,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [3:0]   mem_be,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [N-1:0] mem_rdata
);

    state_t state, state_nx;

    logic [2:0]   funct_q;
    logic [N-1:0] addr_q;
    logic [N-1:0] wdata_q;
    logic         is_ld_q;

    logic         cmd;
    logic         bad;
    logic         hi;
    logic         ld_fin;
    logic [N-1:0] word_addr;
    logic [2*N-1:0] rdata64;
    logic [3:0]   be;
    logic [N-1:0] wsh;
    logic [N-1:0] ld_ext;

    // memRd wins when both commands are raised.
    assign cmd       = memRd | memWr;
    assign word_addr = {addr_q[N-1:2], 2'b00};

`ifdef LSU_MISALIGN_SPLIT_EN
    logic         split;
    logic         split_q;
    logic [N-1:0] rd1_q;

    assign bad     = funct_illegal(memRd, funct);
    assign split   = !bad && misaligned(funct, addr[1:0]);
    assign hi      = (state == REQ2);
    assign rdata64 = (state == WAIT2) ? {mem_rdata, rd1_q}
                                      : {{N{1'b0}}, mem_rdata};
    assign ld_fin  = is_ld_q && mem_rvalid &&
                     ((state == WAIT && !split_q) ||
                      state == WAIT2);
`else
    assign bad     = funct_illegal(memRd, funct) ||
                     misaligned(funct, addr[1:0]);
    assign hi      = 1'b0;
    assign rdata64 = {{N{1'b0}}, mem_rdata};
    assign ld_fin  = is_ld_q && mem_rvalid && (state == WAIT);
`endif

    lsu_align u_align (
        .funct    (funct_q),
        .off      (addr_q[1:0]),
        .hi       (hi),
        .wdata    (wdata_q),
        .rdata    (rdata64),
        .be       (be),
        .wdata_sh (wsh),
        .ld_data  (ld_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (cmd) begin
                    stall    = 1'b1;
                    state_nx = bad ? DONE : REQ;
                end
            end
            REQ: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = !is_ld_q;
                mem_addr  = word_addr;
                mem_be    = be;
                mem_wdata = wsh;
                if (mem_gnt)
                    state_nx = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_nx = split_q ? REQ2 : DONE;
`else
                    state_nx = DONE;
`endif
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            REQ2: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = !is_ld_q;
                mem_addr  = word_addr + N'(4);
                mem_be    = be;
                mem_wdata = wsh;
                if (mem_gnt)
                    state_nx = WAIT2;
            end
            WAIT2: begin
                stall = 1'b1;
                if (mem_rvalid)
                    state_nx = DONE;
            end
`endif
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // stall comes straight from memRd/memWr in IDLE, so mask it
        // while reset is held.
        if (!rst_n)
            stall = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct_q <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            is_ld_q <= 1'b0;
            err     <= 1'b0;
            ld_data <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q <= 1'b0;
            rd1_q   <= '0;
`endif
        end else begin
            if (state == IDLE && cmd) begin
                funct_q <= funct;
                addr_q  <= addr;
                wdata_q <= wdata;
                is_ld_q <= memRd;
                err     <= bad;
                ld_data <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                split_q <= split;
`endif
            end
            if (ld_fin)
                ld_data <= ld_ext;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state == WAIT && mem_rvalid)
                rd1_q <= mem_rdata;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: directed and random load/store traffic against a byte-level
// memory model; a bus responder serves the DUT with configurable grant delay.
`timescale 1ns/1ps
module tb_lsu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRd, memWr;
    logic [2:0]  funct;
    logic [31:0] addr, wdata;
    logic        stall, done, err;
    logic [31:0] ld_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_seq #(.N(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .memRd      (memRd),
        .memWr      (memWr),
        .funct      (funct),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .ld_data    (ld_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus-side memory (written by the responder) and the model's byte view.
    logic [31:0] dmem [16];
    logic [7:0]  rbytes [64];

    task automatic set_word(input int i, input logic [31:0] v);
        dmem[i] = v;
        for (int k = 0; k < 4; k++)
            rbytes[i*4+k] = v[8*k +: 8];
    endtask

    // Responder state.
    int          gnt_delay = 0;
    int          gcnt = 0;
    bit          pend = 0;
    bit          hold_rv = 0;
    logic [31:0] pa;
    logic [31:0] req_addr [$];
    logic [31:0] h_addr, h_wd, cap_wd;
    logic [3:0]  h_be, cap_be;
    logic        h_we, cap_we;

    initial begin
        mem_gnt = 0;
        mem_rvalid = 0;
        mem_rdata = 0;
        forever begin
            @(negedge clk);
            mem_gnt = 0;
            mem_rvalid = 0;
            if (pend && !hold_rv) begin
                mem_rvalid = 1;
                mem_rdata = dmem[pa[5:2]];
                pend = 0;
            end else if (mem_req && !pend) begin
                if (gcnt == 0) begin
                    h_addr = mem_addr;
                    h_be = mem_be;
                    h_wd = mem_wdata;
                    h_we = mem_we;
                end else begin
                    check("hold_addr", mem_addr, h_addr);
                    check("hold_be", 32'(mem_be), 32'(h_be));
                    check("hold_wdata", mem_wdata, h_wd);
                    check("hold_we", 32'(mem_we), 32'(h_we));
                end
                if (gcnt < gnt_delay) begin
                    gcnt++;
                end else begin
                    mem_gnt = 1;
                    gcnt = 0;
                    pend = 1;
                    pa = mem_addr;
                    req_addr.push_back(mem_addr);
                    cap_be = mem_be;
                    cap_wd = mem_wdata;
                    cap_we = mem_we;
                    if (mem_we)
                        for (int k = 0; k < 4; k++)
                            if (mem_be[k])
                                dmem[mem_addr[5:2]][8*k +: 8] =
                                    mem_wdata[8*k +: 8];
                end
            end
        end
    end

    function automatic int mem_mismatch();
        int m = 0;
        for (int i = 0; i < 16; i++)
            if (dmem[i] !== {rbytes[i*4+3], rbytes[i*4+2],
                             rbytes[i*4+1], rbytes[i*4]})
                m++;
        return m;
    endfunction

    // One command through the DUT, compared with the byte-level model.
    task automatic run_op(input string tag, input bit rd, input bit wr,
                          input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input int gd);
        bit          is_ld, illegal, crosses, ok, got;
        int          size, nbeat, exp_lat, cyc;
        logic [31:0] v, exp_ld;
        logic [5:0]  b;

        is_ld = rd;
        if (is_ld)
            illegal = (f == 3'b011 || f == 3'b110 || f == 3'b111);
        else
            illegal = (f[2] == 1'b1 || f == 3'b011);
        size = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        crosses = (int'(a[1:0]) + size) > 4;
`ifdef LSU_MISALIGN_SPLIT_EN
        ok = !illegal;
`else
        ok = !illegal && !crosses;
`endif
        nbeat = (ok && crosses) ? 2 : 1;
        if (!ok)
            exp_lat = 1;
        else
            exp_lat = (nbeat == 2) ? 5 + 2*gd : 3 + gd;

        v = 0;
        exp_ld = 0;
        if (ok && is_ld) begin
            for (int k = 0; k < size; k++) begin
                b = a[5:0] + 6'(k);
                v[8*k +: 8] = rbytes[b];
            end
            if (size == 1)
                exp_ld = f[2] ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            else if (size == 2)
                exp_ld = f[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            else
                exp_ld = v;
        end

        gnt_delay = gd;
        req_addr.delete();
        @(negedge clk);
        memRd = rd;
        memWr = wr;
        funct = f;
        addr = a;
        wdata = wd;
        #1 check({tag, ":stall_acc"}, 32'(stall), 1);
        cyc = 0;
        got = 0;
        while (!got && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done)
                got = 1;
            else
                check({tag, ":stall"}, 32'(stall), 1);
        end
        check({tag, ":done_seen"}, 32'(got), 1);
        if (got) begin
            check({tag, ":latency"}, 32'(cyc), 32'(exp_lat));
            check({tag, ":stall_done"}, 32'(stall), 0);
            check({tag, ":err"}, 32'(err), 32'(!ok));
            if (is_ld || !ok)
                check({tag, ":ld_data"}, ld_data, exp_ld);
            check({tag, ":nreq"}, 32'(req_addr.size()),
                  ok ? 32'(nbeat) : 0);
            if (ok && req_addr.size() > 0)
                check({tag, ":addr0"}, req_addr[0], {a[31:2], 2'b00});
            if (ok && nbeat == 2 && req_addr.size() > 1)
                check({tag, ":addr1"}, req_addr[1],
                      {a[31:2], 2'b00} + 32'd4);
        end
        @(negedge clk);
        memRd = 0;
        memWr = 0;
        @(posedge clk);
        #1;
        check({tag, ":done_pulse"}, 32'(done), 0);
        check({tag, ":err_hold"}, 32'(err), 32'(!ok));
        if (is_ld || !ok)
            check({tag, ":ld_hold"}, ld_data, exp_ld);
        if (ok && !is_ld)
            for (int k = 0; k < size; k++) begin
                b = a[5:0] + 6'(k);
                rbytes[b] = wd[8*k +: 8];
            end
        check({tag, ":mem"}, 32'(mem_mismatch()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w1, w2, up;
        bit rd, wr;

        rst_n = 0;
        memRd = 1;
        memWr = 0;
        funct = 3'b010;
        addr = 0;
        wdata = 0;
        for (int i = 0; i < 16; i++)
            set_word(i, $urandom);
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_req", 32'(mem_req), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_be", 32'(mem_be), 0);
        check("rst_ld", ld_data, 0);
        check("rst_addr", mem_addr, 0);
        @(negedge clk);
        memRd = 0;
        rst_n = 1;

        // LB at offset 1 sign-extends 0x80.
        set_word(3, 32'h0000_8000);
        run_op("lb_sext", 1, 0, 3'b000, 32'h1000_000D, 0, 0);
        check("lb_sext:value", ld_data, 32'hFFFF_FF80);

        // SH at offset 2 lands in the upper lanes.
        run_op("sh_off2", 0, 1, 3'b001, 32'h0000_0016,
               32'hABCD_1234, 0);
        check("sh_off2:be", 32'(cap_be), 32'h0000_000C);
        check("sh_off2:wdata", cap_wd, 32'h1234_0000);
        check("sh_off2:we", 32'(cap_we), 1);

        // Grant held off for four cycles.
        run_op("lw_gnt4", 1, 0, 3'b010, 32'h0000_0020, 0, 4);

        // Illegal width codes.
        run_op("ld_f011", 1, 0, 3'b011, 32'h0000_0008, 0, 0);
        run_op("st_f100", 0, 1, 3'b100, 32'h0000_0008, 32'h55, 0);
        run_op("both_lbu", 1, 1, 3'b100, 32'h0000_0011, 32'h77, 0);

        // LW at offset 2 crosses into the next word.
        w1 = 32'hA1B2_C3D4;
        w2 = 32'h1122_3344;
        set_word(5, w1);
        set_word(6, w2);
        run_op("lw_off2", 1, 0, 3'b010, 32'h0000_0016, 0, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("lw_off2:merge", ld_data, {w2[15:0], w1[31:16]});
`else
        check("lw_off2:err", 32'(err), 1);
`endif
        run_op("sw_off3", 0, 1, 3'b010, 32'h0000_0027,
               32'hCAFE_F00D, 1);
        run_op("lhu_off3", 1, 0, 3'b101, 32'h0000_0027, 0, 0);

        // Reset while waiting on rvalid; the late response is ignored.
        hold_rv = 1;
        gnt_delay = 0;
        @(negedge clk);
        memRd = 1;
        funct = 3'b010;
        addr = 32'h0000_0030;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort:stall_wait", 32'(stall), 1);
        @(negedge clk);
        rst_n = 0;
        memRd = 0;
        #1;
        check("abort:rst_stall", 32'(stall), 0);
        check("abort:rst_req", 32'(mem_req), 0);
        check("abort:rst_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1;
        #1 hold_rv = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("abort:no_done", 32'(done), 0);
            check("abort:no_stall", 32'(stall), 0);
            check("abort:no_req", 32'(mem_req), 0);
        end
        run_op("after_abort", 1, 0, 3'b001, 32'h0000_0032, 0, 0);

        // Random traffic.
        for (int n = 0; n < 80; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr)
                rd = 1;
            up = $urandom;
            if ($urandom_range(0, 3) == 0)
                set_word($urandom_range(0, 15), $urandom);
            run_op($sformatf("rnd%0d", n), rd, wr,
                   3'($urandom_range(0, 7)),
                   {up[31:6], 4'($urandom_range(0, 13)),
                    2'($urandom_range(0, 3))},
                   $urandom, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
